// File: rtl/av2_obu_byte_packer.sv
// Packs a byte-serial OBU stream into little-endian DATA_WIDTH-bit AXI-Stream words.
// Every OBU starts on a fresh word, and the final word of an OBU carries its byte count.
module av2_obu_byte_packer #(
  parameter int DATA_WIDTH = 128
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [7:0]              s_axis_tdata,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  input  logic                    s_axis_tlast,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic                    m_axis_tlast,
  output logic [31:0]             m_pkt_bytes
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int CW    = (BYTES > 1) ? $clog2(BYTES) : 1;

  typedef enum logic {FILL, HOLD} state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [31:0]           pkt_q, pkt_d;
  logic [BYTES-1:0]      hkeep_q, hkeep_d;
  logic                  hlast_q, hlast_d;
  logic [31:0]           hpkt_q, hpkt_d;
  logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
  logic [BYTES-1:0]      tkeep_q, tkeep_d;
  logic                  tvalid_q, tvalid_d;
  logic                  tlast_q, tlast_d;
  logic [31:0]           pbytes_q, pbytes_d;

  logic                  accept, complete, slot_free;
  logic [DATA_WIDTH-1:0] acc_new;
  logic [BYTES-1:0]      keep_new;
  logic [31:0]           pkt_inc;

  assign s_axis_tready = (state_q == FILL);
  assign accept        = s_axis_tvalid && s_axis_tready;
  assign complete      = (cnt_q == CW'(BYTES - 1)) || s_axis_tlast;
  assign slot_free     = !tvalid_q || m_axis_tready;
  assign pkt_inc       = (pkt_q == '1) ? pkt_q : pkt_q + 32'd1;

  always_comb begin
    acc_new  = acc_q;
    keep_new = '0;
    for (int unsigned i = 0; i < BYTES; i++) begin
      if (i == 32'(cnt_q)) acc_new[8*i +: 8] = s_axis_tdata;
      keep_new[i] = (i <= 32'(cnt_q));
    end
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    pkt_d    = pkt_q;
    hkeep_d  = hkeep_q;
    hlast_d  = hlast_q;
    hpkt_d   = hpkt_q;
    tdata_d  = tdata_q;
    tkeep_d  = tkeep_q;
    tlast_d  = tlast_q;
    pbytes_d = pbytes_q;
    tvalid_d = tvalid_q && !m_axis_tready;

    case (state_q)
      FILL: begin
        if (accept) begin
          pkt_d = pkt_inc;
          if (!complete) begin
            acc_d = acc_new;
            cnt_d = cnt_q + CW'(1);
          end else begin
            cnt_d = '0;
            if (s_axis_tlast) pkt_d = '0;
            if (slot_free) begin
              tdata_d  = acc_new;
              tkeep_d  = keep_new;
              tlast_d  = s_axis_tlast;
              pbytes_d = pkt_inc;
              tvalid_d = 1'b1;
              acc_d    = '0;
            end else begin
              // Completed word parks in the accumulator until the output slot drains.
              acc_d   = acc_new;
              hkeep_d = keep_new;
              hlast_d = s_axis_tlast;
              hpkt_d  = pkt_inc;
              state_d = HOLD;
            end
          end
        end
      end
      HOLD: begin
        if (slot_free) begin
          tdata_d  = acc_q;
          tkeep_d  = hkeep_q;
          tlast_d  = hlast_q;
          pbytes_d = hpkt_q;
          tvalid_d = 1'b1;
          acc_d    = '0;
          state_d  = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= FILL;
      acc_q    <= '0;
      cnt_q    <= '0;
      pkt_q    <= '0;
      hkeep_q  <= '0;
      hlast_q  <= 1'b0;
      hpkt_q   <= '0;
      tdata_q  <= '0;
      tkeep_q  <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      pbytes_q <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      pkt_q    <= pkt_d;
      hkeep_q  <= hkeep_d;
      hlast_q  <= hlast_d;
      hpkt_q   <= hpkt_d;
      tdata_q  <= tdata_d;
      tkeep_q  <= tkeep_d;
      tvalid_q <= tvalid_d;
      tlast_q  <= tlast_d;
      pbytes_q <= pbytes_d;
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tkeep  = tkeep_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign m_pkt_bytes   = pbytes_q;

endmodule

// File: tb/tb_av2_obu_byte_packer.sv
// Bench for av2_obu_byte_packer: directed scenarios plus randomized packets and backpressure,
// with output words checked against a queue of words built from each packet's byte list.
module tb_av2_obu_byte_packer;

  localparam int DW = 128;
  localparam int NB = DW / 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    s_axis_tdata;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic          s_axis_tlast;
  logic [DW-1:0] m_axis_tdata;
  logic [NB-1:0] m_axis_tkeep;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic          m_axis_tlast;
  logic [31:0]   m_pkt_bytes;

  av2_obu_byte_packer #(.DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast), .m_pkt_bytes(m_pkt_bytes)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int ready_mode = 0;  // 0: always ready, 1: random, 2: driven by the test
  logic track_tready = 1'b0;
  logic saw_tready_low = 1'b0;

  logic [7:0]    pkt_buf[$];
  logic [DW-1:0] q_data[$];
  logic [NB-1:0] q_keep[$];
  logic          q_last[$];
  logic [31:0]   q_pkt[$];

  always @(posedge clk) begin
    #1;
    if (ready_mode == 0) m_axis_tready = 1'b1;
    else if (ready_mode == 1) m_axis_tready = 1'($urandom_range(0, 1));
  end

  // Output monitor: in-order scoreboard plus hold-stability while stalled.
  logic          held = 1'b0;
  logic [DW+NB+34-1:0] snap;
  always @(negedge clk) begin
    if (track_tready && !s_axis_tready) saw_tready_low = 1'b1;
    if (rst) held = 1'b0;
    else begin
      if (held) begin
        vectors++;
        if ({m_axis_tvalid, m_axis_tlast, m_pkt_bytes, m_axis_tkeep, m_axis_tdata} !== snap) begin
          miscompares++;
          $display("FAIL hold_stable: got %h required %h",
                   {m_axis_tvalid, m_axis_tlast, m_pkt_bytes, m_axis_tkeep, m_axis_tdata}, snap);
        end
      end
      if (m_axis_tvalid && m_axis_tready) begin
        vectors++;
        if (q_data.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_word: got data %h with no word expected", m_axis_tdata);
        end else begin
          logic [DW-1:0] ed; logic [NB-1:0] ek; logic el; logic [31:0] ep;
          ed = q_data.pop_front(); ek = q_keep.pop_front();
          el = q_last.pop_front(); ep = q_pkt.pop_front();
          if (m_axis_tdata !== ed || m_axis_tkeep !== ek || m_axis_tlast !== el ||
              (el && m_pkt_bytes !== ep)) begin
            miscompares++;
            $display("FAIL word: got data %h keep %h last %b pkt %0d, required data %h keep %h last %b pkt %0d",
                     m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_pkt_bytes, ed, ek, el, ep);
          end
        end
      end
      held = m_axis_tvalid && !m_axis_tready;
      snap = {m_axis_tvalid, m_axis_tlast, m_pkt_bytes, m_axis_tkeep, m_axis_tdata};
    end
  end

  // Reference: split the packet into NB-byte chunks, lane 0 first, zero-padded.
  function automatic void model_pkt();
    int n = pkt_buf.size();
    for (int base = 0; base < n; base += NB) begin
      logic [DW-1:0] w = '0;
      logic [NB-1:0] k = '0;
      for (int j = 0; j < NB && base + j < n; j++) begin
        w[8*j +: 8] = pkt_buf[base + j];
        k[j] = 1'b1;
      end
      q_data.push_back(w); q_keep.push_back(k);
      q_last.push_back(base + NB >= n); q_pkt.push_back(32'(n));
    end
  endfunction

  // Called at posedge+1; returns at posedge+1 after the edge that accepted the byte.
  task automatic send_byte(input logic [7:0] d, input logic l);
    logic acc = 1'b0;
    int budget = 0;
    s_axis_tvalid = 1'b1; s_axis_tdata = d; s_axis_tlast = l;
    while (!acc && budget < 1000) begin
      @(negedge clk); acc = s_axis_tready;
      @(posedge clk); #1;
      budget++;
    end
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    if (!acc) begin
      vectors++; miscompares++;
      $display("FAIL send_timeout: got no accept in %0d cycles, required accept", budget);
    end
  endtask

  task automatic send_pkt(input int gap_max);
    model_pkt();
    for (int i = 0; i < pkt_buf.size(); i++) begin
      send_byte(pkt_buf[i], i == pkt_buf.size() - 1);
      if (gap_max > 0) repeat ($urandom_range(0, gap_max)) begin @(posedge clk); #1; end
    end
  endtask

  task automatic drain();
    int budget = 0;
    while (q_data.size() != 0 && budget < 2000) begin @(posedge clk); #1; budget++; end
    vectors++;
    if (q_data.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d words outstanding, required 0", q_data.size());
      q_data.delete(); q_keep.delete(); q_last.delete(); q_pkt.delete();
    end
  endtask

  task automatic check_zero_outputs(input string name);
    vectors++;
    if (m_axis_tdata !== '0 || m_axis_tkeep !== '0 || m_axis_tvalid !== 1'b0 ||
        m_axis_tlast !== 1'b0 || m_pkt_bytes !== 32'd0) begin
      miscompares++;
      $display("FAIL %s: got data %h keep %h valid %b last %b pkt %0d, required all 0", name,
               m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast, m_pkt_bytes);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_zero_outputs("reset_outputs");
    rst = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if (s_axis_tready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_tready: got %b required 1", s_axis_tready);
    end
  endtask

  task automatic test_full_word();
    pkt_buf.delete();
    for (int i = 0; i < 16; i++) pkt_buf.push_back(8'(i));
    model_pkt();
    for (int i = 0; i < 15; i++) send_byte(pkt_buf[i], 1'b0);
    vectors++;
    if (m_axis_tvalid !== 1'b0) begin
      miscompares++;
      $display("FAIL full_word_early: got valid %b required 0", m_axis_tvalid);
    end
    send_byte(pkt_buf[15], 1'b1);
    vectors++;
    if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 128'h0F0E0D0C0B0A09080706050403020100 ||
        m_axis_tkeep !== 16'hFFFF || m_axis_tlast !== 1'b1 || m_pkt_bytes !== 32'd16) begin
      miscompares++;
      $display("FAIL full_word: got valid %b data %h keep %h last %b pkt %0d, required 1 0F0E..0100 FFFF 1 16",
               m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_pkt_bytes);
    end
    drain();
  endtask

  task automatic test_obu_header();
    pkt_buf = '{8'h12, 8'h05, 8'hAA};
    send_pkt(0);
    vectors++;
    if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 128'hAA0512 || m_axis_tkeep !== 16'h0007 ||
        m_axis_tlast !== 1'b1 || m_pkt_bytes !== 32'd3) begin
      miscompares++;
      $display("FAIL obu_header: got valid %b data %h keep %h last %b pkt %0d, required 1 AA0512 0007 1 3",
               m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_pkt_bytes);
    end
    drain();
  endtask

  task automatic test_multi_word();
    pkt_buf.delete();
    for (int i = 0; i < 40; i++) pkt_buf.push_back(8'($urandom));
    saw_tready_low = 1'b0; track_tready = 1'b1;
    send_pkt(0);
    drain();
    track_tready = 1'b0;
    vectors++;
    if (saw_tready_low !== 1'b0) begin
      miscompares++;
      $display("FAIL multi_word_tready: got tready low %b, required never low", saw_tready_low);
    end
  endtask

  task automatic test_backpressure();
    ready_mode = 2; m_axis_tready = 1'b0;
    pkt_buf.delete();
    for (int i = 0; i < 32; i++) pkt_buf.push_back(8'(8'h40 + i));
    send_pkt(0);
    vectors++;
    if (s_axis_tready !== 1'b0 || m_axis_tvalid !== 1'b1 || m_axis_tlast !== 1'b0 ||
        m_axis_tdata !== 128'h4F4E4D4C4B4A49484746454443424140) begin
      miscompares++;
      $display("FAIL bp_hold: got tready %b valid %b last %b data %h, required 0 1 0 4F4E..4140",
               s_axis_tready, m_axis_tvalid, m_axis_tlast, m_axis_tdata);
    end
    repeat (3) begin @(posedge clk); #1; end
    m_axis_tready = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (s_axis_tready !== 1'b1 || m_axis_tvalid !== 1'b1 || m_axis_tlast !== 1'b1 ||
        m_axis_tdata !== 128'h5F5E5D5C5B5A59585756555453525150 || m_pkt_bytes !== 32'd32) begin
      miscompares++;
      $display("FAIL bp_release: got tready %b valid %b last %b data %h pkt %0d, required 1 1 1 5F5E..5150 32",
               s_axis_tready, m_axis_tvalid, m_axis_tlast, m_axis_tdata, m_pkt_bytes);
    end
    ready_mode = 0;
    drain();
  endtask

  task automatic test_back_to_back();
    pkt_buf = '{8'hA1, 8'hA2};
    model_pkt();
    send_byte(8'hA1, 1'b0); send_byte(8'hA2, 1'b1);
    pkt_buf = '{8'hB1, 8'hB2};
    model_pkt();
    send_byte(8'hB1, 1'b0);
    vectors++;
    if (m_axis_tdata !== 128'hA2A1 || m_axis_tkeep !== 16'h0003 || m_pkt_bytes !== 32'd2) begin
      miscompares++;
      $display("FAIL b2b_first: got data %h keep %h pkt %0d, required A2A1 0003 2",
               m_axis_tdata, m_axis_tkeep, m_pkt_bytes);
    end
    send_byte(8'hB2, 1'b1);
    drain();
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) send_byte(8'($urandom), 1'b0);
    rst = 1'b1;
    #1;
    check_zero_outputs("reset_mid");
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    pkt_buf.delete();
    for (int i = 0; i < 16; i++) pkt_buf.push_back(8'(8'hC0 + i));
    send_pkt(0);
    drain();
  endtask

  task automatic test_random();
    int lens[$] = '{1, 15, 16, 17, 31, 32, 33};
    ready_mode = 1;
    for (int p = 0; p < 30; p++) lens.push_back($urandom_range(1, 50));
    foreach (lens[p]) begin
      pkt_buf.delete();
      for (int i = 0; i < lens[p]; i++) pkt_buf.push_back(8'($urandom));
      send_pkt(p % 3);
    end
    ready_mode = 0;
    drain();
  endtask

  initial begin
    rst = 1'b1; s_axis_tdata = '0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; m_axis_tready = 1'b1;
    test_reset();
    test_full_word();
    test_obu_header();
    test_multi_word();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_random();
    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/av2_obu_byte_packer.md
Name: av2_obu_byte_packer

Overview:
- Upstream neighbour of av2_obu_parser.
- Takes the byte-serial OBU stream from the bitstream DMA and packs it into DATA_WIDTH-bit AXI-Stream words for the parser.
- Lane order is little-endian: byte 0 of an OBU always lands in bits [7:0]. This places the OBU header at [7:0] and the size byte at [15:8].
- Each input packet (one OBU, delimited by tlast) starts on a fresh output word, and the packer reports the packet's byte count.

Parameters:
- DATA_WIDTH, 128, output word width in bits. Must be a multiple of 8, range 16..512.
- BYTES (localparam), DATA_WIDTH/8, byte lanes per output word.

Ports:
- clk  input  1  core clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- s_axis_tdata  input  8  input OBU byte.
- s_axis_tvalid  input  1  input byte valid.
- s_axis_tready  output  1  packer can accept a byte.
- s_axis_tlast  input  1  last byte of the OBU.
- m_axis_tdata  output  DATA_WIDTH  packed word; byte n is at [8n+7:8n].
- m_axis_tkeep  output  BYTES  valid-lane mask.
- m_axis_tvalid  output  1  output word valid.
- m_axis_tready  input  1  downstream accepts the word.
- m_axis_tlast  output  1  word holds the last byte of the OBU.
- m_pkt_bytes  output  32  byte count of the OBU; meaningful only when m_axis_tvalid and m_axis_tlast are both 1.

Behaviour:
- Reset (asynchronous, rst=1):
  - m_axis_tdata=0, m_axis_tkeep=0, m_axis_tvalid=0, m_axis_tlast=0, m_pkt_bytes=0.
  - State=FILL, lane counter=0, packet counter=0, accumulator cleared.
  - s_axis_tready is 1 after reset releases.
  - Reset mid-word discards the partial word and any held output word.
- Accumulator:
  - A byte is accepted when s_axis_tvalid and s_axis_tready are both 1.
  - The accepted byte is written to lane cnt, then cnt increments.
  - The packet counter increments on every accepted byte and saturates at 0xFFFFFFFF.
- Word completion: an accepted byte completes the word when cnt==BYTES-1 or s_axis_tlast=1.
- The output slot is free when (m_axis_tvalid==0) or (m_axis_tready==1).
- State FILL:
  - s_axis_tready = 1.
  - If a completing byte is accepted and the slot is free, on the same edge:
    - m_axis_tdata gets the accumulator including the new byte; unfilled lanes are 0.
    - m_axis_tkeep = (1<<(cnt+1))-1.
    - m_axis_tlast = s_axis_tlast.
    - m_pkt_bytes = packet count including this byte.
    - m_axis_tvalid = 1; accumulator and cnt clear.
    - If tlast, the packet counter clears.
  - Latency: the word is visible the cycle after the completing byte is accepted.
  - Throughput: 1 byte/clk, with no bubble at word boundaries.
  - If a completing byte is accepted and the slot is not free: the accumulator holds the word, the tkeep/tlast/pkt_bytes values are latched, and the state goes to HOLD.
- State HOLD:
  - s_axis_tready = 0.
  - When the slot is free, the held word transfers to the output registers on that edge, the accumulator clears, and the state returns to FILL.
- Output handshake:
  - When m_axis_tvalid=1, m_axis_tdata, tkeep, tlast and pkt_bytes stay stable until m_axis_tready=1.
  - If a word is accepted and no new word loads on the same edge, m_axis_tvalid drops to 0. The other output fields may keep their stale values.
  - Accepting one word and loading the next on the same edge keeps m_axis_tvalid=1.
- Packet boundaries:
  - The byte after a tlast always goes to lane 0.
  - A packet never spans a word boundary with another packet.
- Word order: output words leave strictly in arrival order, with no loss or duplication under any backpressure pattern.

Test Plan:
- Bytes 0x00..0x0F, tlast on the 16th byte, m_axis_tready=1 -> one word 0x0F0E0D0C0B0A09080706050403020100, tkeep=0xFFFF, tlast=1, pkt_bytes=16, tvalid high exactly one cycle after the 16th accept.
- OBU bytes 0x12,0x05,0xAA with tlast on 0xAA -> tdata=0x...0000AA0512, tkeep=0x0007, tlast=1, pkt_bytes=3. The parser downstream decodes obu_type=2 and obu_size=5.
- 40 continuous bytes with tlast on byte 40, m_axis_tready=1 -> 3 words with tkeep 0xFFFF, 0xFFFF, 0x00FF; tlast only on the third word; pkt_bytes=40; s_axis_tready never deasserts.
- m_axis_tready=0 while 32 bytes arrive -> first word held stable, s_axis_tready=0 starting the cycle after the 32nd accept. Then raise m_axis_tready -> words 1 and 2 emitted in order; s_axis_tready returns to 1 the cycle after word 1 is accepted.
- Two back-to-back 2-byte OBUs (0xA1,0xA2 tlast / 0xB1,0xB2 tlast) -> two words, tdata 0xA2A1 and 0xB2B1, each tkeep=0x0003, tlast=1, pkt_bytes=2.
- Assert rst for 1 cycle after 5 bytes of an OBU -> all outputs read 0 immediately. A following 16-byte OBU packs starting at lane 0 with pkt_bytes=16.
